vrf_wb_arbiter: RTL and testbench

VRF_WB_ARBITER -- requirements
Module: vrf_wb_arbiter

---
 rtl/vrf_wb_arbiter.sv | 92 +++++++++
 tb/tb_vrf_wb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vrf_wb_arbiter.sv
// Vector register file writeback arbiter with a destination-register scoreboard.
// Grants one of ALU/LSU per cycle, registers the write port, and tracks pending writes.
module vrf_wb_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_addr,
    output logic        rsv_ack,
    input  logic        chk_en,
    input  logic [4:0]  chk_raA,
    input  logic [4:0]  chk_raB,
    output logic        hazard,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_wa,
    input  logic [63:0] alu_wd,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_wa,
    input  logic [63:0] lsu_wd,
    output logic        wen,
    output logic [4:0]  wa,
    output logic [63:0] wd,
    output logic [31:0] busy,
    output logic [5:0]  pend_cnt,
    output logic        idle
);

    typedef enum logic {GNT_ALU = 1'b0, GNT_LSU = 1'b1} grant_t;

    grant_t      last_grant;
    logic        alu_pick;
    logic        xfer;
    logic [4:0]  xfer_wa;
    logic [63:0] xfer_wd;
    logic        clr;
    logic [31:0] busy_nxt;

    // Handshake: a requester transfers in the cycle where its valid and ready are both
    // high; ready is combinational, never depends on a later cycle, and is low in reset.
    always_comb begin
        alu_pick  = alu_valid && (!lsu_valid || (RR_EN == 1'b0) || (last_grant == GNT_LSU));
        alu_ready = !rst && alu_pick;
        lsu_ready = !rst && lsu_valid && !alu_pick;
        xfer      = alu_ready || lsu_ready;
        xfer_wa   = alu_ready ? alu_wa : lsu_wa;
        xfer_wd   = alu_ready ? alu_wd : lsu_wd;
    end

    // A reservation to a busy register is only legal when this cycle's write retires it.
    always_comb begin
        clr     = xfer && busy[xfer_wa];
        rsv_ack = !rst && rsv_valid && (!busy[rsv_addr] || (xfer && (xfer_wa == rsv_addr)));
        busy_nxt = busy;
        if (clr)
            busy_nxt[xfer_wa] = 1'b0;
        if (rsv_ack)
            busy_nxt[rsv_addr] = 1'b1;
    end

    always_comb begin
        hazard = chk_en && (busy[chk_raA] || busy[chk_raB]);
        idle   = (pend_cnt == 6'd0) && !wen;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 32'd0;
            pend_cnt   <= 6'd0;
            wen        <= 1'b0;
            wa         <= 5'd0;
            wd         <= 64'd0;
            last_grant <= GNT_LSU;
        end else begin
            busy <= busy_nxt;
            // Set and clear together leave the bit count unchanged, even on the same register.
            if (rsv_ack && !clr && (pend_cnt != 6'd32))
                pend_cnt <= pend_cnt + 6'd1;
            else if (clr && !rsv_ack && (pend_cnt != 6'd0))
                pend_cnt <= pend_cnt - 6'd1;
            wen <= xfer;
            if (xfer) begin
                wa         <= xfer_wa;
                wd         <= xfer_wd;
                last_grant <= alu_ready ? GNT_ALU : GNT_LSU;
            end
        end
    end

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Directed bench for vrf_wb_arbiter: a round-robin instance and a fixed-priority instance
// share all inputs; expected values are written out by hand for each vector.
module tb_vrf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        chk_en;
    logic [4:0]  chk_raA;
    logic [4:0]  chk_raB;
    logic        alu_valid;
    logic [4:0]  alu_wa;
    logic [63:0] alu_wd;
    logic        lsu_valid;
    logic [4:0]  lsu_wa;
    logic [63:0] lsu_wd;

    logic        rsv_ack, hazard, alu_ready, lsu_ready, wen, idle;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [31:0] busy;
    logic [5:0]  pend_cnt;

    logic        fp_rsv_ack, fp_hazard, fp_alu_ready, fp_lsu_ready, fp_wen, fp_idle;
    logic [4:0]  fp_wa;
    logic [63:0] fp_wd;
    logic [31:0] fp_busy;
    logic [5:0]  fp_pend_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vrf_wb_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ack(rsv_ack),
        .chk_en(chk_en), .chk_raA(chk_raA), .chk_raB(chk_raB), .hazard(hazard),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wa(lsu_wa), .lsu_wd(lsu_wd),
        .wen(wen), .wa(wa), .wd(wd), .busy(busy), .pend_cnt(pend_cnt), .idle(idle)
    );

    vrf_wb_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ack(fp_rsv_ack),
        .chk_en(chk_en), .chk_raA(chk_raA), .chk_raB(chk_raB), .hazard(fp_hazard),
        .alu_valid(alu_valid), .alu_ready(fp_alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
        .lsu_valid(lsu_valid), .lsu_ready(fp_lsu_ready), .lsu_wa(lsu_wa), .lsu_wd(lsu_wd),
        .wen(fp_wen), .wa(fp_wa), .wd(fp_wd), .busy(fp_busy), .pend_cnt(fp_pend_cnt),
        .idle(fp_idle)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; inputs change only here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rsv_valid = 1'b0; rsv_addr = 5'd0;
        alu_valid = 1'b0; alu_wa = 5'd0; alu_wd = 64'd0;
        lsu_valid = 1'b0; lsu_wa = 5'd0; lsu_wd = 64'd0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
    endtask

    logic [1:0] rr_exp [4];

    initial begin
        rst = 1'b1;
        idle_inputs();
        chk_en = 1'b0; chk_raA = 5'd0; chk_raB = 5'd0;

        // Reset: outputs cleared and handshakes blocked even with requests present
        tick();
        rsv_valid = 1'b1; rsv_addr = 5'd3; alu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        check("rst_rsv_ack", rsv_ack, 0);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_lsu_ready", lsu_ready, 0);
        tick();
        check("rst_busy", busy, 0);
        check("rst_pend", pend_cnt, 0);
        check("rst_wen", wen, 0);
        check("rst_idle", idle, 1);
        idle_inputs();
        #2 rst = 1'b0;
        tick();

        // Reserve r5, then see the hazard
        rsv_valid = 1'b1; rsv_addr = 5'd5;
        #1 check("rsv5_ack", rsv_ack, 1);
        tick();
        rsv_valid = 1'b0;
        check("rsv5_busy", busy, 64'h20);
        check("rsv5_pend", pend_cnt, 1);
        check("rsv5_idle", idle, 0);
        chk_en = 1'b1; chk_raA = 5'd5; chk_raB = 5'd0;
        #1 check("haz_a", hazard, 1);
        chk_raA = 5'd0; chk_raB = 5'd5;
        #1 check("haz_b", hazard, 1);
        chk_en = 1'b0;
        #1 check("haz_disabled", hazard, 0);
        chk_en = 1'b1;

        // ALU writeback retires r5
        alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 64'hA5;
        #1;
        check("wb5_alu_ready", alu_ready, 1);
        check("wb5_lsu_ready", lsu_ready, 0);
        check("wb5_haz_pre", hazard, 1);
        tick();
        alu_valid = 1'b0;
        #1;
        check("wb5_wen", wen, 1);
        check("wb5_wa", wa, 5);
        check("wb5_wd", wd, 64'hA5);
        check("wb5_busy", busy, 0);
        check("wb5_pend", pend_cnt, 0);
        check("wb5_haz", hazard, 0);
        check("wb5_idle", idle, 0);
        tick();
        check("hold_wen", wen, 0);
        check("hold_wa", wa, 5);
        check("hold_wd", wd, 64'hA5);
        check("hold_idle", idle, 1);
        chk_en = 1'b0;

        // Tie arbitration after reset: round-robin alternates, fixed priority keeps ALU
        pulse_reset();
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        alu_valid = 1'b1; alu_wa = 5'd1; alu_wd = 64'h11;
        lsu_valid = 1'b1; lsu_wa = 5'd2; lsu_wd = 64'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_grant%0d", i), {lsu_ready, alu_ready}, rr_exp[i]);
            check($sformatf("fp_grant%0d", i), {fp_lsu_ready, fp_alu_ready}, 2'b01);
            tick();
            check($sformatf("rr_wd%0d", i), wd, rr_exp[i][0] ? 64'h11 : 64'h22);
            check($sformatf("fp_wd%0d", i), fp_wd, 64'h11);
        end
        idle_inputs();
        tick();

        // WAW blocking on r7, and reservation allowed alongside the retiring write
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        #1 check("rsv7_ack", rsv_ack, 1);
        tick();
        #1 check("rsv7_block", rsv_ack, 0);
        tick();
        check("rsv7_busy_held", busy, 64'h80);
        check("rsv7_pend_held", pend_cnt, 1);
        lsu_valid = 1'b1; lsu_wa = 5'd7; lsu_wd = 64'h77;
        #1;
        check("waw_lsu_ready", lsu_ready, 1);
        check("waw_ack", rsv_ack, 1);
        tick();
        idle_inputs();
        check("waw_busy", busy, 64'h80);
        check("waw_pend", pend_cnt, 1);
        check("waw_wen", wen, 1);
        check("waw_wa", wa, 7);

        // Write to non-busy r9
        alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 64'h99;
        tick();
        alu_valid = 1'b0;
        check("nb9_wen", wen, 1);
        check("nb9_wa", wa, 9);
        check("nb9_wd", wd, 64'h99);
        check("nb9_busy", busy, 64'h80);
        check("nb9_pend", pend_cnt, 1);

        // Three more reservations, then asynchronous reset with a write on the port
        for (int r = 1; r <= 3; r++) begin
            rsv_valid = 1'b1; rsv_addr = 5'(r);
            tick();
        end
        rsv_valid = 1'b0;
        check("pre_rst_pend", pend_cnt, 4);
        check("pre_rst_busy", busy, 64'h8E);
        alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 64'hBEEF;
        tick();
        check("pre_rst_wen", wen, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_pend", pend_cnt, 0);
        check("arst_wen", wen, 0);
        check("arst_wa", wa, 0);
        check("arst_alu_ready", alu_ready, 0);
        alu_valid = 1'b0;
        #1 rst = 1'b0;
        #1 check("arst_idle", idle, 1);
        tick();
        check("post_rst_wen", wen, 0);
        check("post_rst_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
